// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker
//
// Clocked De Morgan equivalence engine. On start it walks every N-bit vector,
// registers NAND / OR-of-NOTs and NOR / AND-of-NOTs of each vector in a single
// result stage, and compares each identity pair. A mismatch count, the first
// mismatching vector and a pass flag are held once the sweep finishes.
//
// Optional build macro DEMORGAN_FAULT_INJECT_EN: adds parameter FAULT_VEC and
// inverts and_not_o whenever res_vec == FAULT_VEC, so that exactly one mismatch
// per sweep is produced (used to prove the checker catches errors).
//
// Parameters:
//   N          vector width, 1..8
//   FAULT_VEC  vector to corrupt (only with DEMORGAN_FAULT_INJECT_EN)
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request a sweep; honoured only in IDLE or DONE
//   vec             vector currently applied
//   res_valid       result outputs carry a sweep result
//   res_vec         vector the results belong to
//   nand_o, or_not_o, nor_o, and_not_o   registered gate outputs
//   mismatch        either identity differs (qualified by res_valid)
//   busy, done      sweep running / sweep finished (done held)
//   pass            done with zero errors
//   err_cnt         mismatch count, saturating at 2^N
//   first_err_vec   first mismatching vector, 0 if none
//
// State table:
//   IDLE  | after reset, waiting for start
//   SWEEP | applying vec = 0 .. 2^N-1, one per cycle
//   DRAIN | last result on the outputs, accounted on leaving
//   DONE  | results frozen, start launches a new sweep

module demorgan_sweep_checker #(
    parameter int N = 2
`ifdef DEMORGAN_FAULT_INJECT_EN
    , parameter int FAULT_VEC = 0
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] vec,
    output logic         res_valid,
    output logic [N-1:0] res_vec,
    output logic         nand_o,
    output logic         or_not_o,
    output logic         nor_o,
    output logic         and_not_o,
    output logic         mismatch,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [N-1:0] VEC_LAST = {N{1'b1}};
    localparam logic [N:0]   ERR_MAX  = {1'b1, {N{1'b0}}};

    state_t state;
    logic   fault_hit;

`ifdef DEMORGAN_FAULT_INJECT_EN
    localparam logic [N-1:0] FAULT_VEC_L = N'(FAULT_VEC);
    assign fault_hit = (vec == FAULT_VEC_L);
`else
    assign fault_hit = 1'b0;
`endif

    assign mismatch = res_valid & ((nand_o != or_not_o) | (nor_o != and_not_o));
    assign pass     = done & (err_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            vec           <= '0;
            res_valid     <= 1'b0;
            res_vec       <= '0;
            nand_o        <= 1'b1;
            or_not_o      <= 1'b1;
            nor_o         <= 1'b1;
            and_not_o     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= '0;
            first_err_vec <= '0;
        end else begin
            // Account the result currently on the outputs; res_valid is never
            // high in IDLE/DONE, so this cannot collide with a start clear.
            if (mismatch) begin
                if (err_cnt != ERR_MAX)
                    err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0)
                    first_err_vec <= res_vec;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= SWEEP;
                        vec           <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        err_cnt       <= '0;
                        first_err_vec <= '0;
                    end
                end
                SWEEP: begin
                    res_valid <= 1'b1;
                    res_vec   <= vec;
                    nand_o    <= ~(&vec);
                    or_not_o  <= |(~vec);
                    nor_o     <= ~(|vec);
                    and_not_o <= (&(~vec)) ^ fault_hit;
                    // Hold the last vector rather than wrapping to 0.
                    if (vec == VEC_LAST)
                        state <= DRAIN;
                    else
                        vec <= vec + 1'b1;
                end
                DRAIN: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Testbench for demorgan_sweep_checker: five instances (N = 1,2,3,4,8) driven
// with randomized sweeps, stray start pulses, mid-sweep resets and idle gaps,
// checked against a per-vector reference model of the ideal gate functions.

module tb_demorgan_sweep_checker;

    localparam int NI = 5;
    localparam int NS [NI] = '{1, 2, 3, 4, 8};
`ifdef DEMORGAN_FAULT_INJECT_EN
    localparam int FV [NI] = '{1, 2, 5, 9, 200};
`endif

    logic clk;
    logic start_a     [NI];
    logic rst_a       [NI];
    logic [8:0] vec_a [NI];
    logic [8:0] rvec_a[NI];
    logic [8:0] ferr_a[NI];
    logic [9:0] err_a [NI];
    logic [3:0] gates_a[NI];
    logic rv_a [NI];
    logic mm_a [NI];
    logic busy_a [NI];
    logic done_a [NI];
    logic pass_a [NI];

    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int NW = NS[gi];
        logic [NW-1:0] vec_l, rvec_l, ferr_l;
        logic [NW:0]   err_l;
        logic rv_l, na_l, on_l, no_l, an_l, mm_l, bz_l, dn_l, ps_l;

        demorgan_sweep_checker #(
            .N(NW)
`ifdef DEMORGAN_FAULT_INJECT_EN
            , .FAULT_VEC(FV[gi])
`endif
        ) u_dut (
            .clk           (clk),
            .rst           (rst_a[gi]),
            .start         (start_a[gi]),
            .vec           (vec_l),
            .res_valid     (rv_l),
            .res_vec       (rvec_l),
            .nand_o        (na_l),
            .or_not_o      (on_l),
            .nor_o         (no_l),
            .and_not_o     (an_l),
            .mismatch      (mm_l),
            .busy          (bz_l),
            .done          (dn_l),
            .pass          (ps_l),
            .err_cnt       (err_l),
            .first_err_vec (ferr_l)
        );

        assign vec_a[gi]   = 9'(vec_l);
        assign rvec_a[gi]  = 9'(rvec_l);
        assign ferr_a[gi]  = 9'(ferr_l);
        assign err_a[gi]   = 10'(err_l);
        assign gates_a[gi] = {na_l, on_l, no_l, an_l};
        assign rv_a[gi]    = rv_l;
        assign mm_a[gi]    = mm_l;
        assign busy_a[gi]  = bz_l;
        assign done_a[gi]  = dn_l;
        assign pass_a[gi]  = ps_l;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input int idx, input string s);
        return $sformatf("n%0d_%s", NS[idx], s);
    endfunction

    function automatic int fault_of(input int idx);
`ifdef DEMORGAN_FAULT_INJECT_EN
        return FV[idx];
`else
        return -1;
`endif
    endfunction

    // Everything visible right after a reset: idle, no results, gates for vector 0.
    task automatic check_reset_state(input int idx, input string s);
        check(tg(idx, {s, "_ctl"}), {busy_a[idx], done_a[idx], pass_a[idx], rv_a[idx], mm_a[idx]}, 5'b00000);
        check(tg(idx, {s, "_vec"}), vec_a[idx], 0);
        check(tg(idx, {s, "_err"}), err_a[idx], 0);
        check(tg(idx, {s, "_first"}), ferr_a[idx], 0);
        check(tg(idx, {s, "_gates"}), gates_a[idx], 4'b1111);
    endtask

    // Reset while idle/done, with start possibly high too (reset must win).
    task automatic do_reset(input int idx, input int cycles);
        rst_a[idx]   = 1'b1;
        start_a[idx] = 1'($urandom_range(0, 1));
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_a[idx]   = 1'b0;
        start_a[idx] = 1'b0;
        check_reset_state(idx, "rst");
    endtask

    // Full sweep from IDLE or DONE; optionally one stray start pulse while busy.
    task automatic run_sweep(input int idx, input bit glitch, output bit exp_pass);
        int n     = NS[idx];
        int total = 1 << n;
        int fv    = fault_of(idx);
        int g_at;
        int errs  = 0;
        int first = 0;
        int k;
        logic [3:0] eg;
        g_at = glitch ? int'($urandom_range(1, total + 1)) : -1;
        start_a[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[idx] = 1'b0;
        check(tg(idx, "e0_ctl"), {busy_a[idx], done_a[idx], rv_a[idx]}, 3'b100);
        check(tg(idx, "e0_vec"), vec_a[idx], 0);
        check(tg(idx, "e0_err"), err_a[idx], 0);
        for (int c = 1; c <= total + 1; c++) begin
            if (c == g_at) start_a[idx] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_a[idx] = 1'b0;
            if (c <= total) begin
                k  = c - 1;
                eg = {k != total - 1, k != total - 1, k == 0, (k == 0) ^ (k == fv)};
                check(tg(idx, "rvalid"), rv_a[idx], 1);
                check(tg(idx, "res_vec"), rvec_a[idx], k);
                check(tg(idx, "gates"), gates_a[idx], eg);
                check(tg(idx, "mismatch"), mm_a[idx], k == fv);
                check(tg(idx, "vec"), vec_a[idx], (c < total) ? c : total - 1);
                check(tg(idx, "busy_done"), {busy_a[idx], done_a[idx]}, 2'b10);
                if (k == fv) begin
                    if (errs == 0) first = k;
                    errs++;
                end
            end else begin
                check(tg(idx, "fin_ctl"), {busy_a[idx], done_a[idx], rv_a[idx]}, 3'b010);
                check(tg(idx, "fin_pass"), pass_a[idx], errs == 0);
                check(tg(idx, "fin_err"), err_a[idx], errs);
                check(tg(idx, "fin_first"), ferr_a[idx], first);
            end
        end
        exp_pass = (errs == 0);
    endtask

    // Start a sweep and reset it after 'at' cycles (start also held with reset).
    task automatic run_abort(input int idx, input int at);
        start_a[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[idx] = 1'b0;
        repeat (at - 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_a[idx]   = 1'b1;
        start_a[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a[idx]   = 1'b0;
        start_a[idx] = 1'b0;
        check_reset_state(idx, "abort");
        @(posedge clk);
        @(negedge clk);
        check(tg(idx, "abort_stay_idle"), {busy_a[idx], done_a[idx]}, 2'b00);
    endtask

    task automatic idle_hold(input int idx, input int cycles, input bit exp_done, input bit exp_pass);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            check(tg(idx, "hold"), {busy_a[idx], done_a[idx], pass_a[idx]}, {1'b0, exp_done, exp_pass});
        end
    endtask

    initial begin
        bit p;
        int op;
        int iters;
        for (int i = 0; i < NI; i++) begin
            rst_a[i]   = 1'b1;
            start_a[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) rst_a[i] = 1'b0;
        for (int i = 0; i < NI; i++) check_reset_state(i, "init");

        for (int idx = 0; idx < NI; idx++) begin
            run_sweep(idx, 1'b0, p);
            idle_hold(idx, 2, 1'b1, p);
            run_sweep(idx, 1'b1, p);
            if (NS[idx] == 4) begin
                run_abort(idx, 7);
                run_sweep(idx, 1'b0, p);
            end
            iters = (NS[idx] == 8) ? 2 : 6;
            for (int it = 0; it < iters; it++) begin
                op = int'($urandom_range(0, 3));
                case (op)
                    0, 1: begin
                        run_sweep(idx, op[0], p);
                        idle_hold(idx, int'($urandom_range(0, 2)), 1'b1, p);
                    end
                    2: run_abort(idx, int'($urandom_range(1, (1 << NS[idx]) + 1)));
                    default: begin
                        do_reset(idx, int'($urandom_range(1, 3)));
                        idle_hold(idx, 1, 1'b0, 1'b0);
                    end
                endcase
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demorgan_sweep_checker.md
# demorgan_sweep_checker

- Self-checking, parametrised De Morgan equivalence engine.
- On `start`, sweeps every N-bit input vector, evaluates both De Morgan identities in registered form, and compares each pair:
  - type 1: NOT(AND) vs OR-of-NOTs
  - type 2: NOT(OR) vs AND-of-NOTs
- Reports per-vector results, a mismatch count and pass/fail.
- Sits in the week-5 logic lab as the clocked, N-input generalisation of the two-input De Morgan gate blocks. Replaces free-running testbench toggling with a synthesizable sweep.

## Interface

Parameters:
- `N`, default 2: input vector width; legal range 1..8.
- `FAULT_VEC`, default 0: vector at which the fault is injected. Present only with `DEMORGAN_FAULT_INJECT_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sweep; sampled only when idle.
- `vec`  out  N  input vector currently being applied.
- `res_valid`  out  1  result outputs below hold the result for the previous cycle's `vec`.
- `res_vec`  out  N  vector the current results belong to.
- `nand_o`  out  1  ~(&res_vec)
- `or_not_o`  out  1  |(~res_vec)
- `nor_o`  out  1  ~(|res_vec)
- `and_not_o`  out  1  &(~res_vec)
- `mismatch`  out  1  (nand_o != or_not_o) | (nor_o != and_not_o); qualified by `res_valid`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep complete; held until next accepted `start` or `rst`.
- `pass`  out  1  `done` & (`err_cnt` == 0).
- `err_cnt`  out  N+1  number of vectors with `mismatch`; saturates at 2^N.
- `first_err_vec`  out  N  first mismatching vector; 0 if none.

## Operation

- FSM states:
  - IDLE → SWEEP: on `start`.
  - SWEEP → DRAIN: after `vec` = 2^N−1 is applied.
  - DRAIN → DONE: after one cycle.
  - DONE → SWEEP: on `start`.
- IDLE/DONE accept `start`:
  - `vec` ← 0.
  - `busy` ← 1, `done` ← 0.
  - `err_cnt` ← 0, `first_err_vec` ← 0.
- SWEEP:
  - `vec` increments by 1 each cycle.
  - At `vec` = 2^N−1, the next state is DRAIN and `vec` stays at 2^N−1 (no wrap to 0).
- DRAIN:
  - Last result registered.
  - `res_valid` is high for its final cycle.
- DONE:
  - `busy` = 0, `done` = 1.
  - `pass`, `err_cnt` and `first_err_vec` are frozen.
- Result stage:
  - One register stage captures `res_vec` and all four gate outputs from `vec`.
  - `res_valid` = 1 exactly for the 2^N cycles carrying sweep results.
- Error accounting, on each `res_valid & mismatch`:
  - `err_cnt` += 1.
  - If this is the first error of the sweep, `first_err_vec` ← `res_vec`.
- `start` while `busy` is ignored; the sweep is not restarted.
- Reset, including mid-sweep:
  - FSM returns to IDLE.
  - All outputs become 0, except `nand_o`, `or_not_o`, `nor_o`, `and_not_o` = 1 (results for vector 0).
  - Reset takes priority over `start` in the same cycle.

## Timing

- Start-accept edge is E0. `vec` = k is applied after edge Ek, for k = 0..2^N−1.
- Results for k appear after edge Ek+1, with `res_valid` = 1.
- Last result (k = 2^N−1) appears after edge E(2^N), in DRAIN.
- After edge E(2^N+1):
  - `busy` = 0, `done` = 1, `pass` valid.
  - Sweep latency is 2^N+1 cycles from start-accept to `done`.
- `start` held high in DONE starts a new sweep on that edge; `done` falls on the same edge.

## Configuration

- `DEMORGAN_FAULT_INJECT_EN` defined:
  - `and_not_o` is inverted whenever `res_vec` == `FAULT_VEC`.
  - This forces exactly one mismatch per sweep.
  - Used to prove the checker detects errors.
- Not defined:
  - The `FAULT_VEC` parameter is absent.
  - All outputs are the ideal gate functions.
  - `pass` = 1 after every complete sweep.

## Test plan

- Reset then idle, N=2:
  - `rst`=1 for 2 cycles → `busy`=`done`=`pass`=`res_valid`=0, `err_cnt`=0, `nand_o`=`nor_o`=1.
- Full sweep, N=2, no macro:
  - Start pulse → `res_vec` 0,1,2,3 on consecutive cycles.
  - `nand_o`/`or_not_o` = 1,1,1,0; `nor_o`/`and_not_o` = 1,0,0,0.
  - `done`=1, `pass`=1, `err_cnt`=0 exactly 5 cycles after start-accept.
- Fault injection, N=3, macro defined, `FAULT_VEC`=5:
  - Sweep → `mismatch` only on `res_vec`=5.
  - `err_cnt`=1, `first_err_vec`=5, `pass`=0, `done` at cycle 9.
- Ignored start, N=2:
  - Pulse `start` again at cycle 2 of a sweep → sequence is uninterrupted, `done` still at cycle 5.
  - A second start in DONE launches a new sweep and clears `done` on that edge.
- Reset mid-sweep, N=4:
  - Assert `rst` at cycle 7 → next cycle `busy`=0, `vec`=0, `err_cnt`=0.
  - A subsequent start completes in 17 cycles with `pass`=1.
- Width extremes:
  - N=1 → 2 results, `done` at cycle 3.
  - N=8 → 256 results, `done` at cycle 257, `err_cnt` width 9, `pass`=1.
